// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-to-1 valid/ready bus mux with a registered output stage,
// steered either by sel or by fair round-robin arbitration among requesters.
module arb_mux_reg #(
    parameter int WIDTH = 8,
    parameter int NUM_CH = 8,
    localparam int SEL_W = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rr_en,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);
    localparam logic [SEL_W:0] NC = (SEL_W+1)'(NUM_CH);
    logic             load_ok, sel_ok, rr_found, has_grant, xfer;
    logic [SEL_W-1:0] rr_ptr, rr_grant, grant, idx;
    assign load_ok   = !out_valid || out_ready;
    assign sel_ok    = {1'b0, sel} < NC;
    // Scan downwards so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = SEL_W'((int'(rr_ptr) + k) % NUM_CH);
            if (in_valid[idx]) begin
                rr_found = 1'b1;
                rr_grant = idx;
            end
        end
    end
    assign has_grant = rr_en ? rr_found : sel_ok;
    assign grant     = rr_en ? rr_grant : (sel_ok ? sel : '0);
    assign in_ready  = (has_grant && load_ok && !reset) ? (NUM_CH'(1) << grant) : '0;
    assign xfer      = |(in_ready & in_valid);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            sel_err   <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            sel_err <= !rr_en && !sel_ok && |in_valid;
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant*WIDTH +: WIDTH];
                out_ch    <= grant;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (xfer && rr_en)
                rr_ptr <= (grant == SEL_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
        end
    end
endmodule
